// File: rtl/dispatch_fifo_rv.sv
// Valid/ready FIFO between decode and dispatch: arbitrary depth, flush for
// mispredict recovery, occupancy and almost-full for stall logic.
module dispatch_fifo_rv #(
  parameter  int WIDTH        = 32,
  parameter  int DEPTH        = 8,
  parameter  int AFULL_THRESH = DEPTH - 1,
  localparam int CW           = $clog2(DEPTH + 1),
  localparam int PW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign in_ready    = !full || out_ready;
  assign out_valid   = !empty;
  assign out_data    = empty ? '0 : mem[rd_ptr];
  assign almost_full = (count >= CW'(AFULL_THRESH));
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Contents are left stale; only the bookkeeping is cleared.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_fifo_rv.sv
// Scoreboard bench for dispatch_fifo_rv at DEPTH=5, WIDTH=8: a queue model
// predicts every output each cycle before the clock edge.
module tb_dispatch_fifo_rv;
  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             almost_full;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];

  dispatch_fifo_rv #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive, check predicted outputs, then
  // update the model and advance through the next rising edge.
  task automatic step(input logic iv, input logic [WIDTH-1:0] d,
                      input logic ordy, input logic fl);
    logic e_ready, e_valid, do_push, do_pop;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    e_ready = (sb.size() < DEPTH) || ordy;
    e_valid = (sb.size() != 0);
    chk("in_ready",    32'(in_ready),    32'(e_ready));
    chk("out_valid",   32'(out_valid),   32'(e_valid));
    chk("out_data",    32'(out_data),    e_valid ? 32'(sb[0]) : 32'h0);
    chk("count",       32'(count),       32'(sb.size()));
    chk("almost_full", 32'(almost_full), 32'(sb.size() >= DEPTH - 1));
    do_push = iv && e_ready;
    do_pop  = e_valid && ordy;
    if (fl) sb.delete();
    else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_count",     32'(count),     32'h0);
    chk("rst_afull",     32'(almost_full), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then a rejected 6th push.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h16, 1'b0, 1'b0);
    idle();
    chk("full_count", 32'(count), 32'd5);

    // Partial drain, refill across the wrap point, drain everything.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Push and pop together while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("pass_count", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Empty: no bypass, visible next cycle.
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush with a concurrent push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b1, 8'h88, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_data",  32'(out_data),  32'h0);
    chk("arst_count",     32'(count),     32'h0);
    chk("arst_afull",     32'(almost_full), 32'h0);
    chk("arst_in_ready",  32'(in_ready),  32'h1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic, occasional flush.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
